// File: rtl/raw_scoreboard_if.sv
// -----------------------------------------------------------------------------
// raw_scoreboard_if
//
// Purpose: bundles the Decode-stage signals that feed the RAW hazard scoreboard
// and the stall/pending outputs it returns to the hazard unit.
//
// Parameters:
//   NREG  number of architectural registers
//   RW    register index width
//
// Signals (Decode -> scoreboard):
//   ValidD, FlushD, ExtStall           instruction presence / kill / external stall
//   RsD, RtD, UseRsD, UseRtD           source operands and their read enables
//   BranchD, RegWriteD, MemtoRegD      instruction class flags
//   WriteRegD                          destination index
// Signals (scoreboard -> hazard unit):
//   IDHazardStall, lwstall, branchstall, pending_mask
//
// Modports:
//   master  Decode / hazard-unit side (drives instruction fields)
//   slave   scoreboard side
// -----------------------------------------------------------------------------
interface raw_scoreboard_if #(
  parameter int NREG = 32,
  parameter int RW   = 5
);

  logic            ValidD;
  logic            FlushD;
  logic            ExtStall;
  logic [RW-1:0]   RsD;
  logic [RW-1:0]   RtD;
  logic            UseRsD;
  logic            UseRtD;
  logic            BranchD;
  logic            RegWriteD;
  logic            MemtoRegD;
  logic [RW-1:0]   WriteRegD;

  logic            IDHazardStall;
  logic            lwstall;
  logic            branchstall;
  logic [NREG-1:0] pending_mask;

  modport master (
    output ValidD, FlushD, ExtStall,
    output RsD, RtD, UseRsD, UseRtD,
    output BranchD, RegWriteD, MemtoRegD, WriteRegD,
    input  IDHazardStall, lwstall, branchstall, pending_mask
  );

  modport slave (
    input  ValidD, FlushD, ExtStall,
    input  RsD, RtD, UseRsD, UseRtD,
    input  BranchD, RegWriteD, MemtoRegD, WriteRegD,
    output IDHazardStall, lwstall, branchstall, pending_mask
  );

endinterface

// File: rtl/raw_scoreboard.sv
// -----------------------------------------------------------------------------
// raw_scoreboard
//
// Purpose: Decode-stage read-after-write hazard detector for a 5-stage
// F/D/E/M/W pipeline. Every architectural register has a scoreboard entry
// (valid, is_load, age) tracking an in-flight write:
//   age 1 = producer in E, age 2 = producer in M, age 3 = producer in W.
// Entries age by one every clock and retire after W. Stall requests are
// combinational from the current (pre-issue) entries plus the Decode fields,
// so an instruction that reads its own destination does not stall on itself.
//
// Build option:
//   FORWARD_EN defined   - bypass network present: lwstall for load-use,
//                          branchstall for operands not ready for a Decode
//                          branch, IDHazardStall tied low.
//   FORWARD_EN undefined - no bypass; write-first register file, so any source
//                          whose producer has not reached W raises
//                          IDHazardStall; lwstall/branchstall tied low.
//
// Ports:
//   clk    pipeline clock, all state on the rising edge
//   reset  synchronous active-high, invalidates every entry
//   sb     raw_scoreboard_if.slave - Decode fields in, stalls/pending_mask out
// -----------------------------------------------------------------------------
module raw_scoreboard #(
  parameter int NREG = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  raw_scoreboard_if.slave sb
);

  typedef logic [1:0] age_t;

  localparam age_t AGE_E = 2'd1;
  localparam age_t AGE_M = 2'd2;
  localparam age_t AGE_W = 2'd3;

  // Scoreboard entries.
  logic [NREG-1:0] valid_q, valid_d;
  age_t            age_q [NREG];
  age_t            age_d [NREG];
`ifdef FORWARD_EN
  logic [NREG-1:0] load_q, load_d;
`endif

  // Per-source lookup.
  logic chk_a, chk_b;
  age_t age_a, age_b;
`ifdef FORWARD_EN
  logic load_a, load_b;
`endif

  logic decode_live;
  logic id_stall, lw_stall, br_stall;
  logic issue;
  logic write_en;

  // Indices beyond NREG-1 (possible when NREG < 2**RW) have no entry.
  function automatic logic idx_ok(input logic [RW-1:0] idx);
    return int'(idx) < NREG;
  endfunction

  // ---------------------------------------------------------------------------
  // Source lookup: a source only matters when it is actually read and its
  // register has a write in flight.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a value before any condition so no path can
    // leave it unassigned and infer a latch.
    chk_a = 1'b0;
    chk_b = 1'b0;
    age_a = age_q[sb.RsD];
    age_b = age_q[sb.RtD];
`ifdef FORWARD_EN
    load_a = load_q[sb.RsD];
    load_b = load_q[sb.RtD];
`endif
    if (sb.UseRsD && idx_ok(sb.RsD)) chk_a = valid_q[sb.RsD];
    if (sb.UseRtD && idx_ok(sb.RtD)) chk_b = valid_q[sb.RtD];
  end

  // ---------------------------------------------------------------------------
  // Stall decisions. A killed or empty Decode slot never stalls; ExtStall only
  // blocks issue and does not reach the stall outputs.
  // ---------------------------------------------------------------------------
  assign decode_live = sb.ValidD & ~sb.FlushD;

  always_comb begin
    id_stall = 1'b0;
    lw_stall = 1'b0;
    br_stall = 1'b0;
`ifdef FORWARD_EN
    // ALU results forward from M onward; load data only from W onward into E.
    lw_stall = decode_live & ~sb.BranchD &
               ((chk_a & load_a & (age_a < AGE_M)) |
                (chk_b & load_b & (age_b < AGE_M)));
    // A Decode branch needs ALU results out of M and load data out of W.
    br_stall = decode_live & sb.BranchD &
               ((chk_a & (load_a ? (age_a < AGE_W) : (age_a < AGE_M))) |
                (chk_b & (load_b ? (age_b < AGE_W) : (age_b < AGE_M))));
`else
    // Without bypass the value is only readable once the producer is in W.
    id_stall = decode_live &
               ((chk_a & (age_a < AGE_W)) |
                (chk_b & (age_b < AGE_W)));
`endif
  end

  assign issue    = decode_live & ~sb.ExtStall & ~(id_stall | lw_stall | br_stall);
  assign write_en = issue & sb.RegWriteD & (sb.WriteRegD != '0) & idx_ok(sb.WriteRegD);

  assign sb.IDHazardStall = id_stall;
  assign sb.lwstall       = lw_stall;
  assign sb.branchstall   = br_stall;
  assign sb.pending_mask  = valid_q;

  // ---------------------------------------------------------------------------
  // Next-state: age every live entry, retire after W, then let a new issue
  // overwrite its destination (the fresh load beats aging of the same entry).
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    for (int r = 0; r < NREG; r++) begin
      age_d[r] = age_q[r];
    end
`ifdef FORWARD_EN
    load_d = load_q;
`endif

    for (int r = 1; r < NREG; r++) begin
      if (valid_q[r]) begin
        if (age_q[r] == AGE_W) valid_d[r] = 1'b0;
        else                   age_d[r]   = age_q[r] + 2'd1;
      end
    end

    if (write_en) begin
      valid_d[sb.WriteRegD] = 1'b1;
      age_d[sb.WriteRegD]   = AGE_E;
`ifdef FORWARD_EN
      load_d[sb.WriteRegD]  = sb.MemtoRegD;
`endif
    end

    // Register 0 is hard-wired zero and never has a pending write.
    valid_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // NOTE: only the valid bits are reset; age and is_load are never consulted
  // while their entry is invalid, so the payload array carries no reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      age_q[r] <= age_d[r];
    end
`ifdef FORWARD_EN
    load_q <= load_d;
`endif
  end

endmodule
